// File: rtl/keypad_debouncer.sv
// keypad_debouncer: front-end conditioning for the microwave panel.
//   Every raw input is 2-flop synchronized. Start/stop/clear/door are
//   level-debounced. The 10-key pad is debounced through a small FSM
//   that yields one BCD strobe per accepted press.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   key_raw[9:0]        - raw key pad, bit i = digit i
//   startn_raw/stopn_raw/clearn_raw - raw active-low buttons
//   door_raw            - raw door switch, 1 = closed
//   key_code/key_valid  - BCD digit and its one-cycle strobe
//   key_held            - accepted key still down (until release debounced)
//   multi_err           - strobe when >1 key is seen while arming a press
//   startn/stopn/clearn/door_closed - debounced levels

// One synchronized, debounced level. RST_VAL is the safe/inactive level
// used both for the synchronizer and for the output.
module keypad_level_deb #(
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter int   CNT_W           = 10,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= RST_VAL;
      s2    <= RST_VAL;
      cnt   <= '0;
      level <= RST_VAL;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any agreeing sample restarts the count, so a bounce never
      // accumulates toward a change.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module keypad_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] key_raw,
  input  logic       startn_raw,
  input  logic       stopn_raw,
  input  logic       clearn_raw,
  input  logic       door_raw,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err,
  output logic       startn,
  output logic       stopn,
  output logic       clearn,
  output logic       door_closed
);
  // Encoding chosen so key_held is simply state[1] (a flop, glitch-free).
  localparam logic [1:0] IDLE        = 2'b00;
  localparam logic [1:0] DEB_PRESS   = 2'b01;
  localparam logic [1:0] PRESSED     = 2'b10;
  localparam logic [1:0] DEB_RELEASE = 2'b11;

  // The entry cycle (IDLE or first sample of a new candidate) already
  // counts as one stable sample, so the strobe is registered when the
  // count reaches DEBOUNCE_CYCLES-2; release mirrors this.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  // Level inputs, bit order {door, clearn, stopn, startn}.
  localparam logic [3:0] LVL_RST = 4'b0111;

  logic [3:0] lvl_raw, lvl;
  assign lvl_raw = {door_raw, clearn_raw, stopn_raw, startn_raw};

  for (genvar g = 0; g < 4; g++) begin : g_lvl
    keypad_level_deb #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RST_VAL        (LVL_RST[g])
    ) u_deb (
      .clock(clock),
      .reset(reset),
      .raw  (lvl_raw[g]),
      .level(lvl[g])
    );
  end

  assign startn      = lvl[0];
  assign stopn       = lvl[1];
  assign clearn      = lvl[2];
  assign door_closed = lvl[3];

  // Key pad synchronizer
  logic [9:0] ks1, ks;
  always_ff @(posedge clock) begin
    if (reset) begin
      ks1 <= '0;
      ks  <= '0;
    end else begin
      ks1 <= key_raw;
      ks  <= ks1;
    end
  end

  // Classification of the synchronized pad
  logic       ks_zero, ks_multi, ks_onehot;
  logic [3:0] ks_idx;
  logic [3:0] cand;
  logic [9:0] cand_mask;

  assign ks_zero   = (ks == '0);
  assign ks_multi  = ((ks & (ks - 10'd1)) != '0);
  assign ks_onehot = !ks_zero && !ks_multi;
  assign cand_mask = 10'd1 << cand;

  always_comb begin
    ks_idx = '0;
    for (int i = 0; i < 10; i++)
      if (ks[i]) ks_idx = 4'(i);
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  assign key_held = state[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ks_onehot) begin
            cand  <= ks_idx;
            cnt   <= '0;
            state <= DEB_PRESS;
          end else if (ks_multi) begin
            multi_err <= 1'b1;
          end
        end
        DEB_PRESS: begin
          if (ks == cand_mask) begin
            if (cnt == CNT_LAST) begin
              key_code  <= cand;
              key_valid <= 1'b1;
              cnt       <= '0;
              state     <= PRESSED;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (ks_zero) begin
            state <= IDLE;
          end else if (ks_onehot) begin
            cand <= ks_idx;
            cnt  <= '0;
          end else begin
            multi_err <= 1'b1;
            state     <= IDLE;
          end
        end
        PRESSED: begin
          // Extra keys while held are deliberately ignored.
          if (ks_zero) begin
            cnt   <= '0;
            state <= DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (!ks_zero) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_debouncer.sv
module tb_keypad_debouncer;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] key_raw;
  logic       startn_raw, stopn_raw, clearn_raw, door_raw;
  logic [3:0] key_code;
  logic       key_valid, key_held, multi_err;
  logic       startn, stopn, clearn, door_closed;

  keypad_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .key_raw(key_raw),
    .startn_raw(startn_raw), .stopn_raw(stopn_raw),
    .clearn_raw(clearn_raw), .door_raw(door_raw),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .multi_err(multi_err), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed)
  );

  always #5 clock = ~clock;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  logic started = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  // A change is accepted once the last D synchronized samples all call for
  // it. Key acceptance: D identical one-hot samples while not held; held
  // ends after D all-zero samples. multi_err: any multi-key sample while
  // not held.
  logic [9:0] m_s1, m_s2;
  logic [3:0] m_l1, m_l2, m_lvl;   // {door, clearn, stopn, startn}
  logic [9:0] kh[$];
  logic [3:0] lh[$];
  logic       m_held, m_valid, m_err;
  logic [3:0] m_code;

  always @(posedge clock) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_l1 = 4'b0111; m_l2 = 4'b0111;
      kh.delete(); lh.delete();
      m_held = 0; m_valid = 0; m_err = 0; m_code = 0; m_lvl = 4'b0111;
    end else begin
      logic same_oh, all_zero;
      kh.push_back(m_s2); if (kh.size() > D) void'(kh.pop_front());
      lh.push_back(m_l2); if (lh.size() > D) void'(lh.pop_front());
      m_valid = 0; m_err = 0;
      same_oh  = (kh.size() == D) && ($countones(m_s2) == 1);
      all_zero = (kh.size() == D);
      foreach (kh[j]) begin
        if (kh[j] != m_s2) same_oh = 0;
        if (kh[j] != '0) all_zero = 0;
      end
      if (!m_held) begin
        if ($countones(m_s2) > 1) m_err = 1;
        else if (same_oh) begin
          m_valid = 1; m_held = 1;
          for (int b = 0; b < 10; b++) if (m_s2[b]) m_code = 4'(b);
        end
      end else if (all_zero) m_held = 0;
      for (int i = 0; i < 4; i++) begin
        logic chg;
        chg = (lh.size() == D);
        foreach (lh[j]) if (lh[j][i] == m_lvl[i]) chg = 0;
        if (chg) m_lvl[i] = m_l2[i];
      end
      m_s2 = m_s1; m_s1 = key_raw;
      m_l2 = m_l1; m_l1 = {door_raw, clearn_raw, stopn_raw, startn_raw};
    end
  end

  // ---------------- compare + monitors ----------------
  int nvalid = 0, nerr = 0, last_valid_cyc = -1, door_rise_cyc = -1;
  int startn_low = 0, stopn_fall_cyc = -1;
  logic door_prev = 1'b0, stopn_prev = 1'b1;

  always @(negedge clock) begin
    if (started) begin
      chk("outputs",
          {key_code, key_valid, key_held, multi_err, startn, stopn, clearn, door_closed},
          {m_code, m_valid, m_held, m_err, m_lvl[0], m_lvl[1], m_lvl[2], m_lvl[3]});
      if (key_valid) begin nvalid++; last_valid_cyc = cyc; end
      if (multi_err) nerr++;
      if (!startn) startn_low++;
      if (door_closed && !door_prev) door_rise_cyc = cyc;
      if (!stopn && stopn_prev) stopn_fall_cyc = cyc;
      door_prev = door_closed; stopn_prev = stopn;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
  endtask

  task automatic wait_valid(input int n0, input int start, output int lat);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock); #1;
      if (nvalid > n0) begin lat = last_valid_cyc - start; break; end
    end
  endtask

  task automatic wait_release(input int start, output int lat);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock); #1;
      if (!key_held) begin lat = cyc - start; break; end
    end
  endtask

  initial begin
    int s, lat, n0, e0, sl0, khold;
    reset = 1; key_raw = '0; startn_raw = 1; stopn_raw = 1; clearn_raw = 1; door_raw = 0;
    step(1);
    started = 1;
    step(2);
    @(negedge clock); #1;
    chk("rst_outputs", {key_code, key_valid, key_held, multi_err, startn, stopn, clearn, door_closed},
        11'b0000_000_1110);
    step(1); reset = 0;
    step(5);

    // Clean press of key 5
    n0 = nvalid; s = cyc; key_raw = 10'h020;
    wait_valid(n0, s, lat);
    chk("press_latency", lat, 2 + D);
    chk("press_code", key_code, 5);
    chk("press_held", key_held, 1);
    step(5);
    chk("press_single_strobe", nvalid - n0, 1);
    s = cyc; key_raw = '0;
    wait_release(s, lat);
    chk("release_latency", lat, 2 + D);
    step(3);

    // Bounce then stable key 5
    n0 = nvalid;
    for (int i = 0; i < 10; i++) begin
      key_raw = ((i / 2) % 2 == 1) ? 10'h020 : 10'h000; step(1);
    end
    key_raw = 10'h020; s = cyc;
    step(1);
    chk("bounce_no_strobe", nvalid - n0, 0);
    wait_valid(n0, s, lat);
    chk("bounce_latency", lat, 2 + D);
    chk("bounce_code", key_code, 5);
    key_raw = '0; step(12);

    // Two keys at once, then key 9
    n0 = nvalid; e0 = nerr;
    key_raw = 10'h003; step(1); key_raw = '0; step(6);
    chk("multi_err_pulses", nerr - e0, 1);
    chk("multi_no_strobe", nvalid - n0, 0);
    s = cyc; key_raw = 10'h200;
    wait_valid(n0, s, lat);
    chk("key9_latency", lat, 2 + D);
    chk("key9_code", key_code, 9);
    key_raw = '0; step(12);

    // Key 3 held, key 7 added, released, then key 7 alone
    n0 = nvalid; s = cyc; key_raw = 10'h008;
    wait_valid(n0, s, lat);
    chk("key3_code", key_code, 3);
    e0 = nerr; step(2); key_raw = 10'h088; step(8);
    chk("held_extra_no_strobe", nvalid - n0, 1);
    chk("held_extra_no_err", nerr - e0, 0);
    chk("held_extra_code", key_code, 3);
    key_raw = '0; step(10);
    chk("released_idle", key_held, 0);
    n0 = nvalid; s = cyc; key_raw = 10'h080;
    wait_valid(n0, s, lat);
    chk("key7_latency", lat, 2 + D);
    chk("key7_code", key_code, 7);
    key_raw = '0; step(12);

    // Door with one-cycle glitch; short start pulse; clean stop press
    s = cyc; door_raw = 1; step(2); door_raw = 0; step(1); door_raw = 1;
    sl0 = startn_low;
    startn_raw = 0; step(2); startn_raw = 1; step(10);
    chk("door_glitch_rise", door_rise_cyc - s, 3 + 2 + D);
    chk("start_short_ignored", startn_low - sl0, 0);
    s = cyc; stopn_raw = 0; step(10);
    chk("stop_fall_latency", stopn_fall_cyc - s, 2 + D);
    stopn_raw = 1; step(10);

    // Reset during press debounce (cnt=2), key kept down
    n0 = nvalid; key_raw = 10'h010; step(5);
    reset = 1; step(1); reset = 0; s = cyc;
    @(negedge clock); #1;
    chk("midrst_outputs", {key_code, key_valid, key_held, multi_err, startn, stopn, clearn, door_closed},
        11'b0000_000_1110);
    chk("midrst_no_strobe", nvalid - n0, 0);
    wait_valid(n0, s, lat);
    chk("midrst_relatency", lat, 2 + D);
    chk("midrst_code", key_code, 4);
    key_raw = '0; step(12);

    // Randomized traffic
    khold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (khold == 0) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) key_raw = '0;
        else if (r < 9) key_raw = 10'd1 << $urandom_range(0, 9);
        else key_raw = (10'd1 << $urandom_range(0, 9)) | (10'd1 << $urandom_range(0, 9));
        khold = $urandom_range(1, 8);
      end
      khold--;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: startn_raw = ~startn_raw;
          1: stopn_raw  = ~stopn_raw;
          2: clearn_raw = ~clearn_raw;
          default: door_raw = ~door_raw;
        endcase
      end
      reset = ($urandom_range(0, 399) == 0);
      step(1);
    end
    reset = 0; step(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
